// File: rtl/spi_ctrl_initiator.sv
// -----------------------------------------------------------------------------
// spi_ctrl_initiator
//   SPI mode-0 initiator that sends one 16-bit register frame
//   {rw, addr[6:0], data[7:0]} MSB first per start/ready handshake, and
//   captures the final byte returned on cipo for read frames.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready high, ncs high; waits for start
//   SETUP | ncs low, copi = bit15, sclk low for one half-period
//   SHIFT | 32 half-periods of sclk; sample cipo on rise, advance copi on fall
//   HOLD  | sclk low, ncs low, copi holds bit0 for one half-period
//   GAP   | ncs high for one half-period before returning to IDLE
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   start / ready     frame request handshake (accept on start && ready)
//   rw, addr, wdata   frame contents, captured at accept
//   busy              inverse of ready
//   rdata, rdata_valid last read byte and its one-cycle update strobe
//   sclk, ncs, copi   SPI outputs (sclk idles low, ncs active-low)
//   cipo              SPI input, already synchronous to clk
//
// CLK_DIV is the number of clk cycles per sclk half-period (1..255).
// -----------------------------------------------------------------------------
module spi_ctrl_initiator #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       ready,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    input  logic       cipo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  half_cnt_q, half_cnt_d;
    logic [14:0] tx_q, tx_d;        // bits still to send after the one on copi
    logic [7:0]  rx_q, rx_d;        // last eight cipo samples
    logic        rw_q, rw_d;
    logic        ready_q, ready_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        copi_q, copi_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;

    logic        tick;
    logic [15:0] frame;

    assign tick  = (div_cnt_q == 8'd0);
    assign frame = {rw, addr, (rw ? wdata : 8'h00)};

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = tick ? DIV_LOAD : (div_cnt_q - 8'd1);
        half_cnt_d    = half_cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        rw_d          = rw_q;
        ready_d       = ready_q;
        sclk_d        = sclk_q;
        ncs_d         = ncs_q;
        copi_d        = copi_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                div_cnt_d = DIV_LOAD;
                if (start && ready_q) begin
                    state_d    = S_SETUP;
                    rw_d       = rw;
                    tx_d       = frame[14:0];
                    copi_d     = frame[15];
                    rx_d       = 8'h00;
                    half_cnt_d = 5'd0;
                    ncs_d      = 1'b0;
                    ready_d    = 1'b0;
                end
            end
            S_SETUP: begin
                if (tick) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (tick) begin
                    half_cnt_d = half_cnt_q + 5'd1;
                    if (!sclk_q) begin
                        // cipo is sampled on the edge that raises sclk
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], cipo};
                    end else begin
                        sclk_d = 1'b0;
                        if (half_cnt_q == 5'd31) begin
                            state_d = S_HOLD;   // copi keeps bit0 through HOLD
                        end else begin
                            copi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    if (!rw_q) begin
                        rdata_d       = rx_q;
                        rdata_valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= DIV_LOAD;
            half_cnt_q    <= 5'd0;
            tx_q          <= 15'd0;
            rx_q          <= 8'h00;
            rw_q          <= 1'b0;
            ready_q       <= 1'b1;
            sclk_q        <= 1'b0;
            ncs_q         <= 1'b1;
            copi_q        <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            half_cnt_q    <= half_cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            rw_q          <= rw_d;
            ready_q       <= ready_d;
            sclk_q        <= sclk_d;
            ncs_q         <= ncs_d;
            copi_q        <= copi_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = ~ready_q;
    assign sclk        = sclk_q;
    assign ncs         = ncs_q;
    assign copi        = copi_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_spi_ctrl_initiator.sv
// -----------------------------------------------------------------------------
// tb_spi_ctrl_initiator
//   Two initiators (CLK_DIV=4 and CLK_DIV=1) driven by a stimulus process.
//   Each accepted frame pushes its expected bus word and read result into a
//   per-instance queue; a monitor per instance decodes the SPI pins and pops
//   and compares when chip select releases. A simple peripheral model
//   returns a chosen byte in the second half of each frame.
// -----------------------------------------------------------------------------
module tb_spi_ctrl_initiator;

    typedef struct {
        logic [15:0] frame;
        bit          is_read;
        logic [7:0]  resp;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n, start, rw_i, ready, busy, rdata_valid, sclk, ncs, copi, cipo;
    logic [6:0] addr_i    [2];
    logic [7:0] wdata_i   [2];
    logic [7:0] rdata     [2];
    logic [7:0] resp_next [2];
    logic [1:0] abort = 2'b00;

    exp_t exp_q [2][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_ctrl_initiator #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .ready(ready[0]),
        .rw(rw_i[0]), .addr(addr_i[0]), .wdata(wdata_i[0]), .busy(busy[0]),
        .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .sclk(sclk[0]),
        .ncs(ncs[0]), .copi(copi[0]), .cipo(cipo[0])
    );

    spi_ctrl_initiator #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .ready(ready[1]),
        .rw(rw_i[1]), .addr(addr_i[1]), .wdata(wdata_i[1]), .busy(busy[1]),
        .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .sclk(sclk[1]),
        .ncs(ncs[1]), .copi(copi[1]), .cipo(cipo[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_side
        localparam int D = (g == 0) ? 4 : 1;

        // peripheral: eight zero bits then the response byte, MSB first,
        // first bit presented at ncs fall, next bit after each sclk fall
        logic [15:0] sh = '0;
        logic        loaded = 1'b0;
        assign cipo[g] = sh[15];
        always @(negedge sclk[g] or negedge ncs[g] or posedge ncs[g]) begin
            if (ncs[g]) begin
                loaded = 1'b0;
            end else if (!loaded) begin
                sh     = {8'h00, resp_next[g]};
                loaded = 1'b1;
            end else begin
                sh = {sh[14:0], 1'b0};
            end
        end

        initial begin : monitor
            int          cyc, ncs_fall, ready_fall, last_rise, last_fall, nrise;
            logic [15:0] got;
            logic [7:0]  exp_rdata;
            logic        p_sclk, p_ncs, p_ready;
            exp_t        e;
            cyc = 0; ncs_fall = 0; ready_fall = 0; last_rise = 0; last_fall = 0;
            nrise = 0; got = '0; exp_rdata = 8'h00;
            p_sclk = 1'b0; p_ncs = 1'b1; p_ready = 1'b1;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_n[g] === 1'b1 || abort[g]) begin
                    if (p_ready && !ready[g]) begin
                        ready_fall = cyc;
                        chk($sformatf("busy_on_accept[%0d]", g), busy[g], 1);
                    end
                    if (!p_ready && ready[g] && !abort[g])
                        chk($sformatf("ready_low_cycles[%0d]", g), cyc - ready_fall, 35 * D);
                    if (p_ncs && !ncs[g]) begin
                        ncs_fall = cyc;
                        nrise    = 0;
                        got      = '0;
                    end
                    if (!p_sclk && sclk[g]) begin
                        if (nrise > 0)
                            chk($sformatf("sclk_rise_spacing[%0d]", g), cyc - last_rise, 2 * D);
                        last_rise = cyc;
                        got       = {got[14:0], copi[g]};
                        nrise++;
                    end
                    if (p_sclk && !sclk[g]) last_fall = cyc;
                    if (!p_ncs && ncs[g]) begin
                        if (abort[g]) begin
                            exp_rdata = 8'h00;
                            chk($sformatf("abort_pins[%0d]", g),
                                {sclk[g], rdata_valid[g], rdata[g]}, {2'b00, exp_rdata});
                        end else if (exp_q[g].size() == 0) begin
                            chk($sformatf("unexpected_frame[%0d]", g), 1, 0);
                        end else begin
                            e = exp_q[g].pop_front();
                            if (e.is_read) exp_rdata = e.resp;
                            chk($sformatf("copi_frame[%0d]", g), got, e.frame);
                            chk($sformatf("sclk_rises[%0d]", g), nrise, 16);
                            chk($sformatf("ncs_low_cycles[%0d]", g), cyc - ncs_fall, 34 * D);
                            chk($sformatf("fall_to_ncs[%0d]", g), cyc - last_fall, D);
                            chk($sformatf("rdata_valid_at_gap[%0d]", g), rdata_valid[g], e.is_read);
                            chk($sformatf("rdata[%0d]", g), rdata[g], exp_rdata);
                        end
                    end else if (rdata_valid[g]) begin
                        chk($sformatf("stray_rdata_valid[%0d]", g), rdata_valid[g], 0);
                    end
                end
                p_sclk  = sclk[g];
                p_ncs   = ncs[g];
                p_ready = ready[g];
            end
        end
    end

    task automatic send(input int g, input logic r, input logic [6:0] a,
                        input logic [7:0] w, input logic [7:0] resp);
        int to = 0;
        while (!ready[g] && to < 2000) begin
            @(negedge clk);
            to++;
        end
        if (!ready[g]) chk($sformatf("ready_timeout[%0d]", g), ready[g], 1);
        rw_i[g] = r; addr_i[g] = a; wdata_i[g] = w; resp_next[g] = resp;
        start[g] = 1'b1;
        exp_q[g].push_back('{frame: {r, a, (r ? w : 8'h00)}, is_read: !r, resp: resp});
        @(negedge clk);
        start[g] = 1'b0;
        chk($sformatf("accepted[%0d]", g), {ready[g], ncs[g], copi[g]}, {2'b00, r});
        // scramble inputs while busy; the frame must not change
        rw_i[g] = 1'($urandom); addr_i[g] = 7'($urandom); wdata_i[g] = 8'($urandom);
    endtask

    task automatic wait_idle(input int g);
        int to = 0;
        while ((exp_q[g].size() != 0 || !ready[g]) && to < 3000) begin
            @(negedge clk);
            to++;
        end
        chk($sformatf("drain[%0d]", g), {exp_q[g].size() == 0, ready[g]}, 2'b11);
    endtask

    initial begin
        int   n, to, hi_run, min_hi;
        int   acc [3];
        logic p_sclk, p_ready, p_ncs;
        rst_n = 2'b00; start = 2'b00; rw_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_i[i] = '0; wdata_i[i] = '0; resp_next[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("in_reset[%0d]", i),
                {ready[i], busy[i], ncs[i], sclk[i], copi[i], rdata_valid[i], rdata[i]}, 14'b10100_0_00000000);
        rst_n = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("after_reset[%0d]", i),
                {ready[i], busy[i], ncs[i], sclk[i], copi[i], rdata_valid[i], rdata[i]}, 14'b10100_0_00000000);

        send(0, 1'b1, 7'h00, 8'h55, 8'h3C);
        wait_idle(0);
        send(0, 1'b0, 7'h03, 8'hFF, 8'hA5);
        wait_idle(0);

        // start pulse mid-frame with a different address is ignored
        send(0, 1'b1, 7'h12, 8'h34, 8'h00);
        repeat (40) @(negedge clk);
        start[0] = 1'b1; rw_i[0] = 1'b0; addr_i[0] = 7'h55;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);

        // reset after the fifth sclk rise of a read frame
        send(0, 1'b0, 7'h44, 8'h00, 8'h5A);
        n = 0; to = 0; p_sclk = sclk[0];
        while (n < 5 && to < 1000) begin
            @(negedge clk);
            to++;
            if (!p_sclk && sclk[0]) n++;
            p_sclk = sclk[0];
        end
        chk("abort_reach_rise5", n, 5);
        abort[0] = 1'b1;
        void'(exp_q[0].pop_back());
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("abort_next_edge", {ncs[0], sclk[0], ready[0], rdata_valid[0]}, 4'b1010);
        rst_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        abort[0] = 1'b0;
        send(0, 1'b1, 7'h01, 8'h22, 8'h00);
        wait_idle(0);

        for (int k = 0; k < 14; k++) begin
            int gi = (k < 8) ? 0 : 1;
            send(gi, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            wait_idle(gi);
        end

        // back-to-back on the CLK_DIV=1 instance: three frames with start held
        rw_i[1] = 1'b0; addr_i[1] = 7'h2A; wdata_i[1] = 8'hC3; resp_next[1] = 8'h96;
        for (int k = 0; k < 3; k++)
            exp_q[1].push_back('{frame: 16'h2A00, is_read: 1'b1, resp: 8'h96});
        start[1] = 1'b1;
        n = 0; to = 0; hi_run = 0; min_hi = 1000; p_ready = ready[1]; p_ncs = ncs[1];
        while (n < 3 && to < 500) begin
            @(negedge clk);
            to++;
            if (p_ncs && !ncs[1]) begin
                if (n > 0 && hi_run < min_hi) min_hi = hi_run;
                hi_run = 0;
            end
            if (ncs[1]) hi_run++;
            if (p_ready && !ready[1]) begin
                acc[n] = to;
                n++;
            end
            p_ready = ready[1];
            p_ncs   = ncs[1];
        end
        start[1] = 1'b0;
        chk("b2b_frames", n, 3);
        if (n == 3) begin
            // ready is low for 35 cycles, then one IDLE cycle before re-accept
            chk("b2b_spacing_1", acc[1] - acc[0], 36);
            chk("b2b_spacing_2", acc[2] - acc[1], 36);
            chk("b2b_ncs_high_min", min_hi >= 1, 1);
        end
        wait_idle(1);
        wait_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
